// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment scan controller: slot FSM states,
// the active-high hex segment table and the slot-length helper.
package ssd_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } slot_state_e;

  function automatic int tick_div(input int clk_hz, input int refresh_hz);
    return clk_hz / refresh_hz;
  endfunction

  // Segment pattern in gfedcba order, 1 = segment lit.
  function automatic logic [6:0] seg_hex(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      4'hF:    seg = 7'h71;
      default: seg = 7'h00;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/ssd_hex_decoder.sv
// Combinational 4-bit to seven-segment decoder, active-high gfedcba output.
module ssd_hex_decoder
  import ssd_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = seg_hex(nibble);

endmodule

// File: rtl/ssd_scan_controller.sv
// Time-multiplexed common-anode display scanner with per-slot blanking guard,
// frame-aligned double buffering and optional leading-zero suppression.
module ssd_scan_controller
  import ssd_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int REFRESH_HZ   = 10_000,
  parameter int NUM_DIGITS   = 4,
  parameter int BLANK_CYCLES = 100
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      Load,
  input  logic [4*NUM_DIGITS-1:0]   Data_In,
  input  logic [NUM_DIGITS-1:0]     Dp_In,
  input  logic                      Lz_Blank,
  output logic [NUM_DIGITS-1:0]     Anode,
  output logic [6:0]                Cathode,
  output logic                      Dp,
  output logic                      Frame_Start,
  output logic                      Load_Ack
);

  localparam int TICK_DIV = tick_div(CLK_HZ, REFRESH_HZ);
  localparam int CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DIG_W    = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0]      CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0]      CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [DIG_W-1:0]      DIG_ZERO  = {DIG_W{1'b0}};
  localparam logic [DIG_W-1:0]      DIG_ONE   = DIG_W'(1);
  localparam logic [DIG_W-1:0]      DIG_LAST  = DIG_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = {NUM_DIGITS{1'b1}};
  localparam logic [NUM_DIGITS-1:0] ANODE_ONE = NUM_DIGITS'(1);
  localparam slot_state_e           ST_RESET  = (BLANK_CYCLES > 0) ? ST_BLANK : ST_DRIVE;

  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [DIG_W-1:0]                dig_q, dig_d;
  slot_state_e                     state_q, state_d;
  logic [NUM_DIGITS-1:0][3:0]      shadow_data_q, shadow_data_d;
  logic [NUM_DIGITS-1:0]           shadow_dp_q, shadow_dp_d;
  logic [NUM_DIGITS-1:0][3:0]      active_data_q, active_data_d;
  logic [NUM_DIGITS-1:0]           active_dp_q, active_dp_d;
  logic                            pending_q, pending_d;
  logic                            commit_q, commit_d;
  logic [NUM_DIGITS-1:0]           anode_q, anode_d;
  logic [6:0]                      cathode_q, cathode_d;
  logic                            dp_q, dp_d;
  logic                            frame_start_q, frame_start_d;
  logic                            load_ack_q, load_ack_d;

  logic                            frame_wrap;
  logic [3:0]                      cur_nibble;
  logic [6:0]                      cur_seg;
  logic [NUM_DIGITS-1:0]           lz_mask;

  assign frame_wrap = (cnt_q == CNT_LAST) && (dig_q == DIG_LAST);
  assign cur_nibble = active_data_q[dig_q];

  ssd_hex_decoder u_hex_decoder (
    .nibble (cur_nibble),
    .seg    (cur_seg)
  );

  // Slot counter, digit index and BLANK/DRIVE state tracking the next counter value.
  always_comb begin
    cnt_d   = cnt_q;
    dig_d   = dig_q;
    state_d = state_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = CNT_ZERO;
      if (dig_q == DIG_LAST) begin
        dig_d = DIG_ZERO;
      end else begin
        dig_d = dig_q + DIG_ONE;
      end
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
    case (state_q)
      ST_BLANK: state_d = (cnt_d >= CNT_BLANK) ? ST_DRIVE : ST_BLANK;
      ST_DRIVE: state_d = (cnt_d <  CNT_BLANK) ? ST_BLANK : ST_DRIVE;
      default:  state_d = ST_RESET;
    endcase
  end

  // Load always wins the shadow; only a frame wrap moves shadow into active.
  always_comb begin
    shadow_data_d = shadow_data_q;
    shadow_dp_d   = shadow_dp_q;
    active_data_d = active_data_q;
    active_dp_d   = active_dp_q;
    pending_d     = pending_q;
    commit_d      = frame_wrap && pending_q;
    if (frame_wrap && pending_q) begin
      active_data_d = shadow_data_q;
      active_dp_d   = shadow_dp_q;
    end else begin
      active_data_d = active_data_q;
    end
    if (Load) begin
      shadow_data_d = Data_In;
      shadow_dp_d   = Dp_In;
      pending_d     = 1'b1;
    end else if (frame_wrap) begin
      pending_d     = 1'b0;
    end else begin
      pending_d     = pending_q;
    end
  end

  // A digit is suppressed when it and every more significant digit are zero.
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    lz_mask    = {NUM_DIGITS{1'b0}};
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_above = zero_above && (active_data_q[k] == 4'h0);
      lz_mask[k] = Lz_Blank && zero_above && (k != 0);
    end
  end

  always_comb begin
    anode_d       = ANODE_OFF;
    cathode_d     = SEG_OFF;
    dp_d          = 1'b1;
    frame_start_d = (cnt_q == CNT_ZERO) && (dig_q == DIG_ZERO);
    load_ack_d    = commit_q;
    if (state_q == ST_DRIVE) begin
      anode_d   = ~(ANODE_ONE << dig_q);
      cathode_d = lz_mask[dig_q] ? SEG_OFF : ~cur_seg;
      dp_d      = ~active_dp_q[dig_q];
    end else begin
      anode_d   = ANODE_OFF;
      cathode_d = SEG_OFF;
      dp_d      = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_q         <= CNT_ZERO;
      dig_q         <= DIG_ZERO;
      state_q       <= ST_RESET;
      shadow_data_q <= '0;
      shadow_dp_q   <= {NUM_DIGITS{1'b0}};
      active_data_q <= '0;
      active_dp_q   <= {NUM_DIGITS{1'b0}};
      pending_q     <= 1'b0;
      commit_q      <= 1'b0;
      anode_q       <= ANODE_OFF;
      cathode_q     <= SEG_OFF;
      dp_q          <= 1'b1;
      frame_start_q <= 1'b0;
      load_ack_q    <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      dig_q         <= dig_d;
      state_q       <= state_d;
      shadow_data_q <= shadow_data_d;
      shadow_dp_q   <= shadow_dp_d;
      active_data_q <= active_data_d;
      active_dp_q   <= active_dp_d;
      pending_q     <= pending_d;
      commit_q      <= commit_d;
      anode_q       <= anode_d;
      cathode_q     <= cathode_d;
      dp_q          <= dp_d;
      frame_start_q <= frame_start_d;
      load_ack_q    <= load_ack_d;
    end
  end

  assign Anode       = anode_q;
  assign Cathode     = cathode_q;
  assign Dp          = dp_q;
  assign Frame_Start = frame_start_q;
  assign Load_Ack    = load_ack_q;

endmodule

// File: tb/tb_ssd_scan_controller.sv
// Directed frame-by-frame bench: each expected frame is queued when its stimulus is set up
// and popped when the controller scans that frame out.
module tb_ssd_scan_controller;

  logic        Clk;
  logic        Reset;
  logic        Load;
  logic [15:0] Data_In;
  logic [3:0]  Dp_In;
  logic        Lz_Blank;
  logic [3:0]  Anode;
  logic [6:0]  Cathode;
  logic        Dp;
  logic        Frame_Start;
  logic        Load_Ack;

  ssd_scan_controller #(
    .CLK_HZ       (1000),
    .REFRESH_HZ   (100),
    .NUM_DIGITS   (4),
    .BLANK_CYCLES (2)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Load        (Load),
    .Data_In     (Data_In),
    .Dp_In       (Dp_In),
    .Lz_Blank    (Lz_Blank),
    .Anode       (Anode),
    .Cathode     (Cathode),
    .Dp          (Dp),
    .Frame_Start (Frame_Start),
    .Load_Ack    (Load_Ack)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [3:0][6:0] cath;
    logic [3:0]      dp_n;
    logic            ack;
  } frame_exp_t;

  frame_exp_t sb_q[$];
  int n_asserts = 0;
  int n_fails   = 0;

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  function automatic frame_exp_t model(input logic [15:0] data, input logic [3:0] dpv,
                                       input logic lz, input logic ack);
    frame_exp_t e;
    logic       za;
    logic [3:0] nib;
    za = 1'b1;
    for (int k = 3; k >= 0; k--) begin
      nib = data[4*k +: 4];
      za  = za && (nib == 4'h0);
      e.cath[k] = (lz && za && (k != 0)) ? 7'h7F : ~seg_tab[nib];
    end
    e.dp_n = ~dpv;
    e.ack  = ack;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] data, input logic [3:0] dpv, input logic lz,
                      input logic ack);
    sb_q.push_back(model(data, dpv, lz, ack));
  endtask

  task automatic wait_fs(output int n);
    logic found;
    n     = 0;
    found = 1'b0;
    while (!found && n < 100) begin
      @(negedge Clk);
      n++;
      if (Frame_Start === 1'b1) found = 1'b1;
    end
    if (!found) check("fs_timeout", 32'(0), 32'(1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_anode"},   32'(Anode),       32'(4'hF));
    check({tag, "_cathode"}, 32'(Cathode),     32'(7'h7F));
    check({tag, "_dp"},      32'(Dp),          32'(1'b1));
    check({tag, "_fs"},      32'(Frame_Start), 32'(1'b0));
    check({tag, "_ack"},     32'(Load_Ack),    32'(1'b0));
  endtask

  // Scan one whole frame against the oldest queued expectation, optionally pulsing
  // Load at up to two cycle offsets within it (offset 39 lands in the next frame's
  // first counter cycle, offset 38 on the commit edge).
  task automatic run_frame(input int fs_wait,
                           input int idx_a, input logic [15:0] data_a, input logic [3:0] dp_a,
                           input int idx_b, input logic [15:0] data_b, input logic [3:0] dp_b);
    frame_exp_t e;
    int         n;
    int         slot;
    int         pos;
    logic [3:0] an_exp;
    wait_fs(n);
    if (fs_wait > 0) check("fs_latency", 32'(n), 32'(fs_wait));
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 32'(0), 32'(1));
      e = model(16'h0000, 4'h0, 1'b0, 1'b0);
    end else begin
      e = sb_q.pop_front();
    end
    for (int i = 0; i < 40; i++) begin
      if (i > 0) @(negedge Clk);
      slot = i / 10;
      pos  = i % 10;
      check("frame_start", 32'(Frame_Start), 32'(i == 0));
      check("load_ack", 32'(Load_Ack), 32'((i == 0) ? e.ack : 1'b0));
      if (pos < 2) begin
        check($sformatf("blank_anode d%0d", slot), 32'(Anode), 32'(4'hF));
        check($sformatf("blank_cathode d%0d", slot), 32'(Cathode), 32'(7'h7F));
        check($sformatf("blank_dp d%0d", slot), 32'(Dp), 32'(1'b1));
      end else begin
        an_exp = ~(4'b0001 << slot);
        check($sformatf("anode d%0d", slot), 32'(Anode), 32'(an_exp));
        check($sformatf("cathode d%0d", slot), 32'(Cathode), 32'(e.cath[slot]));
        check($sformatf("dp d%0d", slot), 32'(Dp), 32'(e.dp_n[slot]));
      end
      if (i == idx_a) begin
        Load = 1'b1; Data_In = data_a; Dp_In = dp_a;
      end else if (i == idx_b) begin
        Load = 1'b1; Data_In = data_b; Dp_In = dp_b;
      end else begin
        Load = 1'b0; Data_In = 16'($urandom()); Dp_In = 4'($urandom());
      end
    end
    @(posedge Clk);
    #1 Load = 1'b0;
  endtask

  initial begin
    int n;
    Reset    = 1'b1;
    Load     = 1'b0;
    Data_In  = 16'h0000;
    Dp_In    = 4'h0;
    Lz_Blank = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check_reset_outputs("reset");
    @(posedge Clk);
    #1 Reset = 1'b0;

    // Blank display after reset, then load 12AF with the digit-2 point
    push(16'h0000, 4'b0000, 1'b0, 1'b0);
    run_frame(2, 39, 16'h12AF, 4'b0100, -1, 16'h0000, 4'h0);
    push(16'h0000, 4'b0000, 1'b0, 1'b0);
    run_frame(0, -1, 16'h0000, 4'h0, -1, 16'h0000, 4'h0);
    push(16'h12AF, 4'b0100, 1'b0, 1'b1);
    run_frame(0, 39, 16'h0030, 4'b0000, -1, 16'h0000, 4'h0);

    // Leading-zero suppression
    Lz_Blank = 1'b1;
    push(16'h12AF, 4'b0100, 1'b1, 1'b0);
    run_frame(0, -1, 16'h0000, 4'h0, -1, 16'h0000, 4'h0);
    push(16'h0030, 4'b0000, 1'b1, 1'b1);
    run_frame(0, 39, 16'h0000, 4'b0000, -1, 16'h0000, 4'h0);
    push(16'h0030, 4'b0000, 1'b1, 1'b0);
    run_frame(0, -1, 16'h0000, 4'h0, -1, 16'h0000, 4'h0);
    push(16'h0000, 4'b0000, 1'b1, 1'b1);
    run_frame(0, 39, 16'h1111, 4'b0000, -1, 16'h0000, 4'h0);

    // Two loads in one frame: last wins, one acknowledge
    Lz_Blank = 1'b0;
    push(16'h0000, 4'b0000, 1'b0, 1'b0);
    run_frame(0, 15, 16'h2222, 4'b0000, -1, 16'h0000, 4'h0);
    // Pending load plus a second load on the commit edge
    push(16'h2222, 4'b0000, 1'b0, 1'b1);
    run_frame(0, 10, 16'h9ABC, 4'b0011, 38, 16'h5678, 4'b1001);
    push(16'h9ABC, 4'b0011, 1'b0, 1'b1);
    run_frame(0, -1, 16'h0000, 4'h0, -1, 16'h0000, 4'h0);
    push(16'h5678, 4'b1001, 1'b0, 1'b1);
    run_frame(0, 39, 16'h4E3D, 4'b1111, -1, 16'h0000, 4'h0);

    // Reset in the middle of digit 2 drive while a load is pending
    wait_fs(n);
    repeat (25) @(negedge Clk);
    check("pre_reset_anode", 32'(Anode), 32'(4'b1011));
    Reset = 1'b1;
    @(negedge Clk);
    check_reset_outputs("mid_reset");
    @(posedge Clk);
    #1 Reset = 1'b0;
    push(16'h0000, 4'b0000, 1'b0, 1'b0);
    run_frame(2, -1, 16'h0000, 4'h0, -1, 16'h0000, 4'h0);
    push(16'h0000, 4'b0000, 1'b0, 1'b0);
    run_frame(0, -1, 16'h0000, 4'h0, -1, 16'h0000, 4'h0);

    check("scoreboard_drained", 32'(sb_q.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
